// File: rtl/kernel_pkt_filter_if.sv
// rtl/kernel_pkt_filter_if.sv - RC receive FIFO read side and RQ transmit FIFO write side
interface kernel_pkt_filter_if #(
    parameter int DW = 540
);
    logic          rc_rx_ef;
    logic          rc_rx_rd;
    logic [DW-1:0] rc_rx_rdata;
    logic          rq_tx_ff;
    logic          rq_tx_wr;
    logic [DW-1:0] rq_tx_wdata;

    // master: the filter, which strobes both FIFOs
    modport master (
        input  rc_rx_ef,
        input  rc_rx_rdata,
        input  rq_tx_ff,
        output rc_rx_rd,
        output rq_tx_wr,
        output rq_tx_wdata
    );

    // slave: the FIFO pair around the filter
    modport slave (
        output rc_rx_ef,
        output rc_rx_rdata,
        output rq_tx_ff,
        input  rc_rx_rd,
        input  rq_tx_wr,
        input  rq_tx_wdata
    );
endinterface

// File: rtl/kernel_pkt_filter.sv
// rtl/kernel_pkt_filter.sv - store-and-forward packet filter between RC rx FIFO and RQ tx FIFO
module kernel_pkt_filter #(
    parameter int A_DTH   = 6,
    parameter int DW      = 540,
    parameter int EOP_POS = 519,
    parameter int ERR_POS = 518,
    parameter int CNT_W   = 32
) (
    input  logic                 clk_kernel,
    input  logic                 rst_kernel,
    kernel_pkt_filter_if.master  fifo_if,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     pkt_fwd_cnt,
    output logic [CNT_W-1:0]     pkt_err_cnt,
    output logic [CNT_W-1:0]     pkt_ovf_cnt,
    output logic                 busy
);
    localparam int MAX_WORDS = 2 ** A_DTH;
    localparam int PW        = A_DTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        SEND = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state_q;
    logic              rd_q;
    logic              rvalid_q;
    logic              ovf_q;
    logic              drop_ovf_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic              rdv_q;
    logic              wr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     buf_dout_q;
    logic [DW-1:0]     mem_q [MAX_WORDS];

    logic              rx_word;
    logic              rx_eop;
    logic              rx_err;
    logic              at_last_slot;
    logic              buf_wr;
    logic              buf_rd;
    logic              rd_d;
    logic              send_done;
    logic              fwd_inc;
    logic              err_inc;
    logic              ovf_inc;

    assign rx_word      = (state_q == RECV) && rvalid_q;
    assign rx_eop       = fifo_if.rc_rx_rdata[EOP_POS];
    assign rx_err       = fifo_if.rc_rx_rdata[ERR_POS];
    assign at_last_slot = (wptr_q == PW'(MAX_WORDS - 1));
    assign buf_wr       = rx_word && !ovf_q;

    // The read strobe is registered, so data returns the cycle after rd_q; a
    // returning EOP word must suppress the next read so the following packet
    // is not touched before this one has been forwarded or dropped.
    assign rd_d = (state_q == RECV) && !fifo_if.rc_rx_ef && !rd_q && !(rx_word && rx_eop);

    // wptr_q holds the word count once the packet is complete, so the last
    // valid index is wptr_q-1.
    assign buf_rd    = (state_q == SEND) && !fifo_if.rq_tx_ff && (rptr_q < wptr_q);
    assign send_done = (state_q == SEND) && wr_q && !rdv_q && (rptr_q == wptr_q);

    assign fwd_inc = send_done;
    assign err_inc = (state_q == DROP) && !drop_ovf_q;
    assign ovf_inc = (state_q == DROP) && drop_ovf_q;

    always_ff @(posedge clk_kernel) begin
        if (buf_wr) begin
            mem_q[wptr_q[A_DTH-1:0]] <= fifo_if.rc_rx_rdata;
        end
        if (buf_rd) begin
            buf_dout_q <= mem_q[rptr_q[A_DTH-1:0]];
        end
    end

    always_ff @(posedge clk_kernel or posedge rst_kernel) begin
        if (rst_kernel) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            ovf_q      <= 1'b0;
            drop_ovf_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rdv_q      <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            rd_q     <= rd_d;
            rvalid_q <= rd_q;
            rdv_q    <= buf_rd;
            wr_q     <= rdv_q;
            if (rdv_q) begin
                wdata_q <= buf_dout_q;
            end

            case (state_q)
                IDLE: begin
                    if (!fifo_if.rc_rx_ef) begin
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (rx_word) begin
                        if (rx_eop) begin
                            if (!ovf_q) begin
                                wptr_q <= wptr_q + PW'(1);
                            end
                            if (ovf_q) begin
                                drop_ovf_q <= 1'b1;
                                state_q    <= DROP;
                            end else if (rx_err) begin
                                drop_ovf_q <= 1'b0;
                                state_q    <= DROP;
                            end else begin
                                state_q <= SEND;
                            end
                        end else if (!ovf_q) begin
                            // Last slot filled without EOP: keep draining, stop storing.
                            if (at_last_slot) begin
                                ovf_q <= 1'b1;
                            end else begin
                                wptr_q <= wptr_q + PW'(1);
                            end
                        end
                    end
                end
                SEND: begin
                    if (buf_rd) begin
                        rptr_q <= rptr_q + PW'(1);
                    end
                    if (send_done) begin
                        wptr_q  <= '0;
                        rptr_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    wptr_q     <= '0;
                    rptr_q     <= '0;
                    ovf_q      <= 1'b0;
                    drop_ovf_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Clear has priority: an increment landing in the clear cycle is lost.
    always_ff @(posedge clk_kernel or posedge rst_kernel) begin
        if (rst_kernel) begin
            pkt_fwd_cnt <= '0;
            pkt_err_cnt <= '0;
            pkt_ovf_cnt <= '0;
        end else if (cnt_clr) begin
            pkt_fwd_cnt <= '0;
            pkt_err_cnt <= '0;
            pkt_ovf_cnt <= '0;
        end else begin
            if (fwd_inc) pkt_fwd_cnt <= sat_inc(pkt_fwd_cnt);
            if (err_inc) pkt_err_cnt <= sat_inc(pkt_err_cnt);
            if (ovf_inc) pkt_ovf_cnt <= sat_inc(pkt_ovf_cnt);
        end
    end

    assign fifo_if.rc_rx_rd    = rd_q;
    assign fifo_if.rq_tx_wr    = wr_q;
    assign fifo_if.rq_tx_wdata = wdata_q;
    assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_kernel_pkt_filter.sv
// tb/tb_kernel_pkt_filter.sv - scoreboard bench for kernel_pkt_filter
module tb_kernel_pkt_filter;
    localparam int A_DTH   = 6;
    localparam int DW      = 540;
    localparam int EOP_POS = 519;
    localparam int ERR_POS = 518;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] fwd_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ovf_cnt;
    logic             busy;

    kernel_pkt_filter_if #(.DW(DW)) fif ();

    kernel_pkt_filter #(
        .A_DTH(A_DTH), .DW(DW), .EOP_POS(EOP_POS), .ERR_POS(ERR_POS), .CNT_W(CNT_W)
    ) dut (
        .clk_kernel (clk),
        .rst_kernel (rst),
        .fifo_if    (fif),
        .cnt_clr    (cnt_clr),
        .pkt_fwd_cnt(fwd_cnt),
        .pkt_err_cnt(err_cnt),
        .pkt_ovf_cnt(ovf_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int wr_seen = 0;
    logic [DW-1:0] rcq[$];
    logic [DW-1:0] sbq[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input int id, input int idx, input bit eop, input bit err);
        logic [31:0]   p;
        logic [DW-1:0] w;
        p = 32'(id * 256 + idx) ^ 32'hC3A5_0000;
        w = DW'({17{p}});
        w[EOP_POS] = eop;
        w[ERR_POS] = err;
        return w;
    endfunction

    // RC FIFO model: a pop on rc_rx_rd, data presented the following cycle.
    initial begin
        logic rd_s;
        fif.rc_rx_ef    = 1'b1;
        fif.rc_rx_rdata = '0;
        forever begin
            @(negedge clk);
            rd_s = fif.rc_rx_rd;
            @(posedge clk);
            #1;
            if (rd_s) begin
                checks++;
                if (rcq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_on_empty: got read with 0 words queued, required none");
                end else begin
                    fif.rc_rx_rdata = rcq.pop_front();
                    pops++;
                end
            end
            fif.rc_rx_ef = (rcq.size() == 0);
        end
    end

    // RQ side monitor
    initial begin
        forever begin
            @(negedge clk);
            if (fif.rq_tx_wr) begin
                wr_seen++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected no write", fif.rq_tx_wdata);
                end else begin
                    check("wdata", fif.rq_tx_wdata, sbq.pop_front());
                end
            end
        end
    end

    task automatic send_pkt(input int id, input int n, input bit err_last, input bit fwd, input int skip);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = mkword(id, i, i == n - 1, err_last && (i == n - 1));
            rcq.push_back(w);
            if (fwd && i >= skip) sbq.push_back(w);
        end
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(rcq.size() == 0 && sbq.size() == 0 && !busy) && cyc < 3000);
        check(name, (cyc >= 3000), 0);
    endtask

    initial begin
        int base_wr;
        int base_pops;
        int w0;
        int cyc;
        fif.rq_tx_ff = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("rst_rd", fif.rc_rx_rd, 0);
        check("rst_wr", fif.rq_tx_wr, 0);
        check("rst_wdata", fif.rq_tx_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_cnts", {fwd_cnt, err_cnt, ovf_cnt}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        base_wr = wr_seen;
        send_pkt(1, 4, 0, 1, 0);
        wait_done("t1_done");
        check("t1_writes", wr_seen - base_wr, 4);
        check("t1_fwd", fwd_cnt, 1);
        check("t1_busy", busy, 0);

        send_pkt(2, 3, 1, 0, 0);
        wait_done("t2_done");
        check("t2_err", err_cnt, 1);
        check("t2_fwd", fwd_cnt, 1);
        send_pkt(3, 2, 0, 1, 0);
        wait_done("t2b_done");
        check("t2b_fwd", fwd_cnt, 2);

        base_wr = wr_seen;
        base_pops = pops;
        send_pkt(4, 70, 0, 0, 0);
        wait_done("t3_done");
        check("t3_pops", pops - base_pops, 70);
        check("t3_writes", wr_seen - base_wr, 0);
        check("t3_ovf", ovf_cnt, 1);
        check("t3_err", err_cnt, 1);

        send_pkt(5, 66, 1, 0, 0);
        wait_done("t3b_done");
        check("t3b_ovf_prio", ovf_cnt, 2);
        check("t3b_err", err_cnt, 1);

        send_pkt(6, 64, 0, 1, 0);
        wait_done("t3c_done");
        check("t3c_full_fwd", fwd_cnt, 3);

        base_wr = wr_seen;
        send_pkt(7, 8, 0, 1, 0);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (wr_seen == base_wr && cyc < 500);
        check("t4_first_wr_timeout", (cyc >= 500), 0);
        fif.rq_tx_ff = 1'b1;
        w0 = wr_seen;
        repeat (10) @(negedge clk);
        #1;
        check("t4_writes_after_ff_le2", (wr_seen - w0 <= 2), 1);
        fif.rq_tx_ff = 1'b0;
        wait_done("t4_done");
        check("t4_writes", wr_seen - base_wr, 8);
        check("t4_fwd", fwd_cnt, 4);

        base_pops = pops;
        send_pkt(8, 5, 0, 1, 2);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (pops - base_pops < 2 && cyc < 200);
        check("t5_pop_timeout", (cyc >= 200), 0);
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_rd", fif.rc_rx_rd, 0);
        check("t5_wr", fif.rq_tx_wr, 0);
        check("t5_cnts", {fwd_cnt, err_cnt, ovf_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done("t5_done");
        check("t5_pops", pops - base_pops, 5);
        check("t5_fwd", fwd_cnt, 1);

        for (int k = 0; k < 6; k++) begin
            send_pkt(10 + k, 1, 0, 1, 0);
            wait_done("t6_single_done");
        end
        check("t6_fwd_max", fwd_cnt, 7);
        send_pkt(20, 1, 0, 1, 0);
        wait_done("t6_sat_done");
        check("t6_fwd_sat", fwd_cnt, 7);

        send_pkt(21, 2, 0, 1, 0);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(fif.rq_tx_wr && fif.rq_tx_wdata[EOP_POS]) && cyc < 200);
        check("t7_eop_timeout", (cyc >= 200), 0);
        cnt_clr = 1'b1;
        @(negedge clk);
        #1;
        cnt_clr = 1'b0;
        check("t7_clr_wins", fwd_cnt, 0);
        wait_done("t7_done");
        check("t7_busy", busy, 0);
        check("end_queues", rcq.size() + sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
